// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared arbiter state encoding and master-index constants.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_M1 = 2'd1,
        ST_GRANT_M2 = 2'd2,
        ST_RESUME   = 2'd3
    } arb_state_t;

    localparam logic c_M1 = 1'b0;
    localparam logic c_M2 = 1'b1;

    function automatic logic other_master(input logic m);
        return ~m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/split_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : split_timeout_counter
// Description : Counts cycles of an outstanding split; o_expire is high in the
//               last allowed cycle. TIMEOUT = 0 never expires.
// Revision    : 1.0 - initial release
// ============================================================================
module split_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_clear,
    output logic o_expire
);

    localparam int c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic               r_active;
    logic [c_CNT_W-1:0] r_count;

    // Expiry coincides with the TIMEOUT-th edge since the split was parked
    assign o_expire = (TIMEOUT != 0) && r_active && (r_count == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_count  <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_count  <= '0;
        end else if (i_clear || o_expire) begin
            r_active <= 1'b0;
            r_count  <= '0;
        end else if (r_active) begin
            r_count  <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/split_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : split_bus_arbiter
// Description : Two-master bus arbiter with split-transaction parking/resume.
//               Optional macro ARB_ROUND_ROBIN_EN selects round-robin instead
//               of fixed M1 priority.
// Revision    : 1.0 - initial release
// ============================================================================
module split_bus_arbiter
    import bus_pkg::*;
#(
    parameter int SPLIT_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic m1_req,
    input  logic m2_req,
    output logic m1_grant,
    output logic m2_grant,
    input  logic split_ack,
    input  logic split_req,
    output logic split_grant,
    output logic m1_parked,
    output logic m2_parked,
    output logic split_timeout,
    output logic split_err,
    output logic bus_busy
);

    arb_state_t r_state, w_state_nxt;
    logic r_owner, w_owner_nxt;
    logic r_m1_parked, w_m1_parked_nxt;
    logic r_m2_parked, w_m2_parked_nxt;
    logic r_split_pend, w_split_pend_nxt;
    logic r_split_err, w_split_err_nxt;
    logic r_split_timeout, w_split_timeout_nxt;
    logic r_m1_grant, r_m2_grant, r_split_grant, r_bus_busy;
    logic w_m1_grant_nxt, w_m2_grant_nxt, w_split_grant_nxt, w_bus_busy_nxt;
    logic w_ctr_start, w_ctr_clear, w_expire;
    logic w_any_parked, w_resume, w_cur_owner, w_owner_req;
    logic w_elig1, w_elig2, w_pick;
`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_next, w_rr_next_nxt;
`endif

    split_timeout_counter #(
        .TIMEOUT (SPLIT_TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_ctr_start),
        .i_clear  (w_ctr_clear),
        .o_expire (w_expire)
    );

    assign w_any_parked = r_m1_parked | r_m2_parked;
    assign w_resume     = (r_state == ST_IDLE) && w_any_parked && (split_req || r_split_pend);
    assign w_cur_owner  = (r_state == ST_GRANT_M2) ? c_M2 :
                          (r_state == ST_RESUME)   ? r_owner : c_M1;
    assign w_owner_req  = (w_cur_owner == c_M1) ? m1_req : m2_req;
    assign w_elig1      = m1_req & ~r_m1_parked;
    assign w_elig2      = m2_req & ~r_m2_parked;
`ifdef ARB_ROUND_ROBIN_EN
    assign w_pick       = r_rr_next;
`else
    assign w_pick       = c_M1;
`endif

    always_comb begin
        w_state_nxt         = r_state;
        w_owner_nxt         = r_owner;
        w_m1_parked_nxt     = r_m1_parked;
        w_m2_parked_nxt     = r_m2_parked;
        w_split_err_nxt     = r_split_err;
        w_split_timeout_nxt = 1'b0;
        w_ctr_start         = 1'b0;
        w_ctr_clear         = 1'b0;
        // A split_req seen while the bus is owned is remembered until served
        w_split_pend_nxt    = r_split_pend | (split_req & w_any_parked);
`ifdef ARB_ROUND_ROBIN_EN
        w_rr_next_nxt       = r_rr_next;
`endif

        if (w_expire && !w_resume) begin
            w_m1_parked_nxt     = 1'b0;
            w_m2_parked_nxt     = 1'b0;
            w_split_pend_nxt    = 1'b0;
            w_split_timeout_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_resume) begin
                    w_state_nxt      = ST_RESUME;
                    w_owner_nxt      = r_m1_parked ? c_M1 : c_M2;
                    w_m1_parked_nxt  = 1'b0;
                    w_m2_parked_nxt  = 1'b0;
                    w_split_pend_nxt = 1'b0;
                    w_ctr_clear      = 1'b1;
                end else if (w_elig1 && w_elig2) begin
                    w_owner_nxt = w_pick;
                    w_state_nxt = (w_pick == c_M1) ? ST_GRANT_M1 : ST_GRANT_M2;
                end else if (w_elig1) begin
                    w_owner_nxt = c_M1;
                    w_state_nxt = ST_GRANT_M1;
                end else if (w_elig2) begin
                    w_owner_nxt = c_M2;
                    w_state_nxt = ST_GRANT_M2;
                end
            end
            ST_GRANT_M1, ST_GRANT_M2, ST_RESUME: begin
                if (split_ack) begin
                    w_state_nxt = ST_IDLE;
                    if (w_any_parked) begin
                        w_split_err_nxt = 1'b1;
                    end else begin
                        if (w_cur_owner == c_M1) w_m1_parked_nxt = 1'b1;
                        else                     w_m2_parked_nxt = 1'b1;
                        w_ctr_start = 1'b1;
                    end
                end else if (!w_owner_req) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_owner_nxt = w_cur_owner;
                    w_state_nxt = (w_cur_owner == c_M1) ? ST_GRANT_M1 : ST_GRANT_M2;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

`ifdef ARB_ROUND_ROBIN_EN
        if (r_state == ST_IDLE && w_state_nxt != ST_IDLE)
            w_rr_next_nxt = other_master(w_owner_nxt);
`endif

        w_m1_grant_nxt    = (w_state_nxt == ST_GRANT_M1) ||
                            (w_state_nxt == ST_RESUME && w_owner_nxt == c_M1);
        w_m2_grant_nxt    = (w_state_nxt == ST_GRANT_M2) ||
                            (w_state_nxt == ST_RESUME && w_owner_nxt == c_M2);
        w_split_grant_nxt = (w_state_nxt == ST_RESUME);
        w_bus_busy_nxt    = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_owner         <= c_M1;
            r_m1_parked     <= 1'b0;
            r_m2_parked     <= 1'b0;
            r_split_pend    <= 1'b0;
            r_split_err     <= 1'b0;
            r_split_timeout <= 1'b0;
            r_m1_grant      <= 1'b0;
            r_m2_grant      <= 1'b0;
            r_split_grant   <= 1'b0;
            r_bus_busy      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_owner         <= w_owner_nxt;
            r_m1_parked     <= w_m1_parked_nxt;
            r_m2_parked     <= w_m2_parked_nxt;
            r_split_pend    <= w_split_pend_nxt;
            r_split_err     <= w_split_err_nxt;
            r_split_timeout <= w_split_timeout_nxt;
            r_m1_grant      <= w_m1_grant_nxt;
            r_m2_grant      <= w_m2_grant_nxt;
            r_split_grant   <= w_split_grant_nxt;
            r_bus_busy      <= w_bus_busy_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rr_next <= c_M1;
        else     r_rr_next <= w_rr_next_nxt;
    end
`endif

    assign m1_grant      = r_m1_grant;
    assign m2_grant      = r_m2_grant;
    assign split_grant   = r_split_grant;
    assign m1_parked     = r_m1_parked;
    assign m2_parked     = r_m2_parked;
    assign split_timeout = r_split_timeout;
    assign split_err     = r_split_err;
    assign bus_busy      = r_bus_busy;

endmodule
`default_nettype wire

// File: tb/tb_split_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_split_bus_arbiter
// Description : Directed scoreboard bench for split_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_split_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m1_req = 1'b0, m2_req = 1'b0, split_ack = 1'b0, split_req = 1'b0;
    logic m1_grant, m2_grant, split_grant, m1_parked, m2_parked;
    logic split_timeout, split_err, bus_busy;
    logic [7:0] obs;

    // {m1_grant, m2_grant, split_grant, m1_parked, m2_parked, split_timeout, split_err, bus_busy}
    localparam logic [7:0] c_IDLE    = 8'b0000_0000;
    localparam logic [7:0] c_G1      = 8'b1000_0001;
    localparam logic [7:0] c_G2      = 8'b0100_0001;
    localparam logic [7:0] c_P1      = 8'b0001_0000;
    localparam logic [7:0] c_G2P1    = 8'b0101_0001;
    localparam logic [7:0] c_RES1    = 8'b1010_0001;
    localparam logic [7:0] c_TO      = 8'b0000_0100;
    localparam logic [7:0] c_P1ERR   = 8'b0001_0010;
    localparam logic [7:0] c_RES1ERR = 8'b1010_0011;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] q_exp[$];
    string      q_name[$];

    split_bus_arbiter #(
        .SPLIT_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m1_req        (m1_req),
        .m2_req        (m2_req),
        .m1_grant      (m1_grant),
        .m2_grant      (m2_grant),
        .split_ack     (split_ack),
        .split_req     (split_req),
        .split_grant   (split_grant),
        .m1_parked     (m1_parked),
        .m2_parked     (m2_parked),
        .split_timeout (split_timeout),
        .split_err     (split_err),
        .bus_busy      (bus_busy)
    );

    assign obs = {m1_grant, m2_grant, split_grant, m1_parked, m2_parked,
                  split_timeout, split_err, bus_busy};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b", name, act, exp);
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic step(input logic a, input logic b, input logic sa, input logic sr,
                        input logic [7:0] e, input string name);
        @(negedge clk);
        m1_req    = a;
        m2_req    = b;
        split_ack = sa;
        split_req = sr;
        q_exp.push_back(e);
        q_name.push_back(name);
    endtask

    initial begin
        forever begin
            logic [7:0] e;
            string      n;
            @(posedge clk);
            #1;
            if (q_exp.size() != 0) begin
                e = q_exp.pop_front();
                n = q_name.pop_front();
                chk(n, obs, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want finish earlier");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_hold", obs, c_IDLE);
        rst = 1'b0;

        // simultaneous requests, twice
        step(1, 1, 0, 0, c_G1,   "both_first");
        step(0, 0, 0, 0, c_IDLE, "both_first_rel");
`ifdef ARB_ROUND_ROBIN_EN
        step(1, 1, 0, 0, c_G2,   "both_second");
`else
        step(1, 1, 0, 0, c_G1,   "both_second");
`endif
        step(0, 0, 0, 0, c_IDLE, "both_second_rel");

        // five-cycle M1 transaction
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, c_G1, "m1_hold");
        step(0, 0, 0, 0, c_IDLE, "m1_release");

        // split, M2 in between, held split_req, resume (coincides with timeout edge)
        step(1, 0, 0, 0, c_G1,   "c_grant");
        step(1, 0, 1, 0, c_P1,   "c_park");
        step(1, 1, 0, 0, c_G2P1, "c_m2_grant");
        step(1, 1, 0, 1, c_G2P1, "c_sreq_held");
        step(1, 0, 0, 0, c_P1,   "c_m2_release");
        step(1, 0, 0, 0, c_RES1, "c_resume");
        step(1, 0, 0, 0, c_G1,   "c_resume_hold");
        step(0, 0, 0, 0, c_IDLE, "c_release");

        step(0, 0, 0, 1, c_IDLE, "sreq_unparked");

        // timeout after four parked cycles
        step(1, 0, 0, 0, c_G1,   "d_grant");
        step(1, 0, 1, 0, c_P1,   "d_park");
        step(0, 0, 0, 0, c_P1,   "d_wait1");
        step(0, 0, 0, 0, c_P1,   "d_wait2");
        step(0, 0, 0, 0, c_P1,   "d_wait3");
        step(0, 0, 0, 0, c_TO,   "d_timeout");
        step(0, 0, 0, 0, c_IDLE, "d_after");

        // second split_ack while parked, then resume and reset mid-RESUME
        step(1, 0, 0, 0, c_G1,      "e_grant");
        step(1, 0, 1, 0, c_P1,      "e_park");
        step(0, 1, 0, 0, c_G2P1,    "e_m2_grant");
        step(0, 1, 1, 0, c_P1ERR,   "e_second_ack");
        step(0, 0, 0, 1, c_RES1ERR, "e_resume");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset", obs, c_IDLE);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, c_IDLE, "post_reset");

        for (int i = 0; i < 10 && q_exp.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (q_exp.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, want 0", q_exp.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
